// File: rtl/osmosis_pkg.sv
// Shared constants, FSM encoding and membrane permeability rule for the osmosis display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package osmosis_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int MEM_X_DEF = 316;
    localparam int MEM_W_DEF = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FROZEN  = 2'd1,
        RESPAWN = 2'd2
    } state_e;

    // Mode bits OR together; magenta never grants passage on its own.
    function automatic logic membrane_permit(
        input logic is_red,
        input logic membrane_on,
        input logic no_membrane,
        input logic red_membrane,
        input logic blue_membrane,
        input logic magenta_membrane
    );
        return !membrane_on | no_membrane | (red_membrane & is_red)
             | (blue_membrane & !is_red) | (magenta_membrane & 1'b0);
    endfunction

endpackage

// File: rtl/molecule_axis_step.sv
// One-axis motion step: advance by speed, clamp at [lo, hi] and reverse direction on contact.
// Latency: combinational.
// Backpressure: none.
module molecule_axis_step (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [3:0] speed,
    input  logic [9:0] lo,
    input  logic [9:0] hi,
    output logic [9:0] pos_nxt,
    output logic       dir_nxt
);

    logic signed [10:0] sum;

    // Signed intermediate so a step below zero compares as negative, not as a large value.
    always_comb begin
        sum     = dir ? ($signed({1'b0, pos}) + $signed({7'b0, speed}))
                      : ($signed({1'b0, pos}) - $signed({7'b0, speed}));
        pos_nxt = sum[9:0];
        dir_nxt = dir;
        if (sum < $signed({1'b0, lo})) begin
            pos_nxt = lo;
            dir_nxt = ~dir;
        end else if (sum > $signed({1'b0, hi})) begin
            pos_nxt = hi;
            dir_nxt = ~dir;
        end
    end

endmodule

// File: rtl/molecule_gen.sv
// Parametrised molecule: frame-rate motion with wall bounce, colour-selective membrane, crossing count, sprite match.
// Latency: position updates on the frame cycle; side_right/crossings follow one cycle later; is_molecule combinational.
// Backpressure: none; all inputs sampled every cycle.
module molecule_gen
    import osmosis_pkg::*;
#(
    parameter bit IS_RED   = 1'b1,
    parameter int SIZE     = 16,
    parameter int START_X  = 100,
    parameter int START_Y  = 100,
    parameter bit START_DX = 1'b1,
    parameter bit START_DY = 1'b1,
    parameter int SPEED_X  = 2,
    parameter int SPEED_Y  = 1,
    parameter int ARENA_X0 = 0,
    parameter int ARENA_X1 = H_ACTIVE,
    parameter int ARENA_Y0 = 0,
    parameter int ARENA_Y1 = V_ACTIVE,
    parameter int MEM_X    = MEM_X_DEF,
    parameter int MEM_W    = MEM_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       membrane_on,
    input  logic       no_membrane,
    input  logic       red_membrane,
    input  logic       blue_membrane,
    input  logic       magenta_membrane,
    input  logic       freeze,
    input  logic       btnD,
    output logic       is_red,
    output logic       is_molecule,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       side_right,
    output logic [7:0] crossings
);

    localparam logic [9:0]  ST_X       = 10'(START_X);
    localparam logic [9:0]  ST_Y       = 10'(START_Y);
    localparam logic [9:0]  X_LO       = 10'(ARENA_X0);
    localparam logic [9:0]  X_HI       = 10'(ARENA_X1 - SIZE);
    localparam logic [9:0]  Y_LO       = 10'(ARENA_Y0);
    localparam logic [9:0]  Y_HI       = 10'(ARENA_Y1 - SIZE);
    localparam logic [3:0]  SPD_X      = 4'(SPEED_X);
    localparam logic [3:0]  SPD_Y      = 4'(SPEED_Y);
    localparam logic [10:0] SZ         = 11'(SIZE);
    localparam logic [10:0] MEM_L      = 11'(MEM_X);
    localparam logic [10:0] MEM_R      = 11'(MEM_X + MEM_W);
    localparam logic [9:0]  STOP_L     = 10'(MEM_X - SIZE);
    localparam logic [9:0]  STOP_R     = 10'(MEM_X + MEM_W);
    localparam bit          SIDE_RESET = (START_X >= MEM_X + MEM_W);

    state_e     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic       side_right_q, side_right_d;
    logic [7:0] crossings_q, crossings_d;

    logic [9:0] x_step, y_step;
    logic       x_step_dir, y_step_dir;
    logic       permit, block_lr, block_rl;

    molecule_axis_step u_step_y (
        .pos     (pos_y_q),
        .dir     (dy_q),
        .speed   (SPD_Y),
        .lo      (Y_LO),
        .hi      (Y_HI),
        .pos_nxt (y_step),
        .dir_nxt (y_step_dir)
    );

    molecule_axis_step u_step_x (
        .pos     (pos_x_q),
        .dir     (dx_q),
        .speed   (SPD_X),
        .lo      (X_LO),
        .hi      (X_HI),
        .pos_nxt (x_step),
        .dir_nxt (x_step_dir)
    );

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        permit       = membrane_permit(IS_RED, membrane_on, no_membrane, red_membrane,
                                       blue_membrane, magenta_membrane);
        // A molecule straddling the membrane satisfies neither test and moves freely.
        block_lr     = !permit && (({1'b0, pos_x_q} + SZ) <= MEM_L)
                                && (({1'b0, x_step} + SZ) > MEM_L);
        block_rl     = !permit && ({1'b0, pos_x_q} >= MEM_R) && ({1'b0, x_step} < MEM_R);

        case (state_q)
            RUN:     state_d = btnD ? RESPAWN : (freeze ? FROZEN : RUN);
            FROZEN:  state_d = btnD ? RESPAWN : (freeze ? FROZEN : RUN);
            RESPAWN: state_d = btnD ? RESPAWN : (freeze ? FROZEN : RUN);
            default: state_d = RUN;
        endcase

        if (btnD) begin
            pos_x_d = ST_X;
            pos_y_d = ST_Y;
            dx_d    = START_DX;
            dy_d    = START_DY;
        end else if (state_q == RUN && frame) begin
            pos_y_d = y_step;
            dy_d    = y_step_dir;
            pos_x_d = x_step;
            dx_d    = x_step_dir;
            if (block_lr) begin
                pos_x_d = STOP_L;
                dx_d    = ~dx_q;
            end else if (block_rl) begin
                pos_x_d = STOP_R;
                dx_d    = ~dx_q;
            end
        end

        side_right_d = ({1'b0, pos_x_q} >= MEM_R);
        crossings_d  = crossings_q + 8'(side_right_d != side_right_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pos_x_q      <= ST_X;
            pos_y_q      <= ST_Y;
            dx_q         <= START_DX;
            dy_q         <= START_DY;
            side_right_q <= SIDE_RESET;
            crossings_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            side_right_q <= side_right_d;
            crossings_q  <= crossings_d;
        end
    end

    assign is_red      = IS_RED;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign side_right  = side_right_q;
    assign crossings   = crossings_q;
    assign is_molecule = ({1'b0, h_cnt} >= {1'b0, pos_x_q}) && ({1'b0, h_cnt} < ({1'b0, pos_x_q} + SZ))
                      && ({1'b0, v_cnt} >= {1'b0, pos_y_q}) && ({1'b0, v_cnt} < ({1'b0, pos_y_q} + SZ));

endmodule

// File: tb/tb_molecule_gen.sv
// Four differently parametrised molecules on shared stimulus; expectations queued before each step, popped after.
module tb_molecule_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, frame, membrane_on, no_membrane, red_membrane, blue_membrane;
    logic       magenta_membrane, freeze, btnD;
    logic [9:0] h_cnt, v_cnt;

    logic       ir [4];
    logic       im [4];
    logic [9:0] px [4];
    logic [9:0] py [4];
    logic       sr [4];
    logic [7:0] cr [4];

    int compared   = 0;
    int mismatched = 0;
    string tag_q[$];
    int    exp_q[$];

    `define MOL(INST, IDX, RED, SX, SY, DY, SPY) \
    molecule_gen #(.IS_RED(RED), .START_X(SX), .START_Y(SY), .START_DY(DY), .SPEED_Y(SPY)) INST ( \
        .clk(clk), .reset(reset), .frame(frame), .h_cnt(h_cnt), .v_cnt(v_cnt), \
        .membrane_on(membrane_on), .no_membrane(no_membrane), .red_membrane(red_membrane), \
        .blue_membrane(blue_membrane), .magenta_membrane(magenta_membrane), .freeze(freeze), \
        .btnD(btnD), .is_red(ir[IDX]), .is_molecule(im[IDX]), .pos_x(px[IDX]), .pos_y(py[IDX]), \
        .side_right(sr[IDX]), .crossings(cr[IDX]));

    `MOL(u0, 0, 1'b0, 100, 100, 1'b1, 1)
    `MOL(u1, 1, 1'b0, 298, 100, 1'b1, 1)
    `MOL(u2, 2, 1'b1, 298, 100, 1'b1, 1)
    `MOL(u3, 3, 1'b0, 623, 1,   1'b0, 2)

    task automatic expect_v(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input int obs);
        string t;
        int    e;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_underflow observed=%0d", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame = 1'b0; freeze = 1'b0; btnD = 1'b0;
        membrane_on = 1'b1; red_membrane = 1'b1; no_membrane = 1'b0;
        blue_membrane = 1'b0; magenta_membrane = 1'b0;
        h_cnt = 10'd0; v_cnt = 10'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        expect_v("u0_x_rst", 100); expect_v("u0_y_rst", 100); expect_v("u0_cross_rst", 0);
        expect_v("u0_is_red", 0);  expect_v("u2_is_red", 1);
        expect_v("u2_side_rst", 0); expect_v("u3_side_rst", 1);
        pop_check(px[0]); pop_check(py[0]); pop_check(cr[0]);
        pop_check(ir[0]); pop_check(ir[2]); pop_check(sr[2]); pop_check(sr[3]);

        // frame 1: blue u1 reaches the membrane face without entering it
        expect_v("f1_u0_x", 102); expect_v("f1_u0_y", 101); expect_v("f1_u1_x", 300);
        expect_v("f1_u2_x", 300); expect_v("f1_u3_x", 624); expect_v("f1_u3_y", 0);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]); pop_check(px[1]);
        pop_check(px[2]); pop_check(px[3]); pop_check(py[3]);

        // frame 2: u1 blocked by red membrane, u2 passes, u3 bounced off walls
        expect_v("f2_u0_x", 104); expect_v("f2_u0_y", 102); expect_v("f2_u1_x", 300);
        expect_v("f2_u2_x", 302); expect_v("f2_u3_x", 622); expect_v("f2_u3_y", 2);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]); pop_check(px[1]);
        pop_check(px[2]); pop_check(px[3]); pop_check(py[3]);

        expect_v("f3_u0_x", 106); expect_v("f3_u0_y", 103); expect_v("f3_u0_cross", 0);
        expect_v("f3_u1_x", 298); expect_v("f3_u2_x", 304); expect_v("f3_u3_x", 620);
        expect_v("f3_u3_y", 4);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]); pop_check(cr[0]); pop_check(px[1]);
        pop_check(px[2]); pop_check(px[3]); pop_check(py[3]);

        for (int k = 1; k <= 10; k++) begin
            expect_v("walk_u2_x", 304 + 2 * k); expect_v("walk_u2_side", 0); expect_v("walk_u2_cross", 0);
            pulse_frame();
            pop_check(px[2]); pop_check(sr[2]); pop_check(cr[2]);
        end
        expect_v("u2_side_after", 1); expect_v("u2_cross_after", 1);
        @(negedge clk);
        pop_check(sr[2]); pop_check(cr[2]);

        // freeze arriving with a frame: that step still lands
        freeze = 1'b1;
        expect_v("frz_edge_x", 128); expect_v("frz_edge_y", 114);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]);
        repeat (5) pulse_frame();
        expect_v("frozen_x", 128); expect_v("frozen_y", 114);
        pop_check(px[0]); pop_check(py[0]);

        btnD = 1'b1;
        @(negedge clk);
        btnD = 1'b0;
        expect_v("respawn_x", 100); expect_v("respawn_y", 100);
        pop_check(px[0]); pop_check(py[0]);
        @(negedge clk);
        expect_v("refrozen_x", 100); expect_v("refrozen_y", 100);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]);

        h_cnt = 10'd115; v_cnt = 10'd100; expect_v("spr_right_in", 1); #1 pop_check(im[0]);
        h_cnt = 10'd116; expect_v("spr_right_out", 0); #1 pop_check(im[0]);
        h_cnt = 10'd99;  expect_v("spr_left_out", 0);  #1 pop_check(im[0]);
        h_cnt = 10'd100; v_cnt = 10'd115; expect_v("spr_bot_in", 1); #1 pop_check(im[0]);
        v_cnt = 10'd116; expect_v("spr_bot_out", 0); #1 pop_check(im[0]);
        @(negedge clk);

        freeze = 1'b0;
        @(negedge clk);
        expect_v("thaw_x", 102); expect_v("thaw_y", 101);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]);

        // btnD and frame together: respawn wins
        btnD = 1'b1; frame = 1'b1;
        @(negedge clk);
        btnD = 1'b0; frame = 1'b0;
        expect_v("btn_frame_x", 100); expect_v("btn_frame_y", 100);
        pop_check(px[0]); pop_check(py[0]);
        @(negedge clk);
        expect_v("rerun_x", 102); expect_v("rerun_y", 101);
        pulse_frame();
        pop_check(px[0]); pop_check(py[0]);

        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
